dynode_baseline: RTL and testbench

Upstream stage of the dynode event detector. It takes raw 12-bit dynode ADC samples at 100 MHz and keeps a running baseline, averaged over blocks of quiet samples. It subtracts that baseline to produce the baseline-corrected stream dyn_blcor, which the event detector smooths and differentiates. Baseline learning is gated off while a pulse is present and for a holdoff period afterwards, so that pulse tails do not bias the baseline.

---
 rtl/dynode_pkg.sv | 27 ++
 rtl/dynode_baseline_if.sv | 20 ++
 rtl/dynode_bl_accum.sv | 48 ++++
 rtl/dynode_baseline.sv | 145 ++++++++++++++
 tb/tb_dynode_baseline.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dynode_pkg.sv
`default_nettype none
// ============================================================================
// dynode_pkg : widths, thresholds and baseline FSM encodings shared by the
//              dynode baseline tracker and the event detector.  Rev 1.0
// ============================================================================
package dynode_pkg;

  localparam int              ADC_W    = 12;
  localparam int              AVG_LOG2 = 4;
  localparam logic [ADC_W-1:0] GATE_THR = 12'd64;
  localparam logic [7:0]      HOLDOFF  = 8'd16;
  localparam logic [9:0]      MAXPULSE = 10'd511;

  localparam logic [1:0] BL_INIT  = 2'd0;
  localparam logic [1:0] BL_QUIET = 2'd1;
  localparam logic [1:0] BL_PULSE = 2'd2;
  localparam logic [1:0] BL_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT  = BL_INIT,
    ST_QUIET = BL_QUIET,
    ST_PULSE = BL_PULSE,
    ST_HOLD  = BL_HOLD
  } bl_state_e;

endpackage
`default_nettype wire

// File: rtl/dynode_baseline_if.sv
`default_nettype none
// ============================================================================
// dynode_baseline_if : raw ADC input and baseline-corrected outputs.  Rev 1.0
// ============================================================================
interface dynode_baseline_if;
  import dynode_pkg::*;

  logic [ADC_W-1:0] adc_raw;
  logic [ADC_W-1:0] dyn_blcor;
  logic [ADC_W-1:0] baseline;
  logic             bl_valid;
  logic             bl_gate;
  logic             bl_relearn;

  modport master (output adc_raw,
                  input  dyn_blcor, baseline, bl_valid, bl_gate, bl_relearn);
  modport slave  (input  adc_raw,
                  output dyn_blcor, baseline, bl_valid, bl_gate, bl_relearn);
endinterface
`default_nettype wire

// File: rtl/dynode_bl_accum.sv
`default_nettype none
// ============================================================================
// dynode_bl_accum : block accumulator with wrapping sample count; sum already
//                   includes the current input.  Rev 1.0
// ============================================================================
module dynode_bl_accum #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    add_en,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W+CNT_W-1:0] sum,
  output logic                    wrap
);

  logic [DATA_W+CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign sum  = acc_q + {{CNT_W{1'b0}}, din};
  assign wrap = add_en && !clear && (cnt_q == '1);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = wrap ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dynode_baseline.sv
`default_nettype none
// ============================================================================
// dynode_baseline : gated running-baseline tracker and subtractor for the
//                   dynode ADC stream.  Rev 1.0
// ============================================================================
module dynode_baseline
  import dynode_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  dynode_baseline_if.slave bus
);

  localparam int SUM_W = ADC_W + AVG_LOG2;

  bl_state_e        state_q, state_d;
  logic [ADC_W-1:0] adc_d_q, adc_d_d;
  logic [ADC_W-1:0] dyn_blcor_q, dyn_blcor_d;
  logic [ADC_W-1:0] baseline_q, baseline_d;
  logic             bl_valid_q, bl_valid_d;
  logic             bl_gate_q, bl_gate_d;
  logic             bl_relearn_q, bl_relearn_d;
  logic [9:0]       pcnt_q, pcnt_d;
  logic [7:0]       hold_q, hold_d;

  logic             acc_clear, acc_add, acc_wrap;
  logic [SUM_W-1:0] acc_sum;
  logic [ADC_W-1:0] block_avg;
  logic signed [ADC_W:0] diff;
  logic             over_thr;
  logic [9:0]       pcnt_inc;
  logic             timeout;

  dynode_bl_accum #(.DATA_W(ADC_W), .CNT_W(AVG_LOG2)) u_accum (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .add_en (acc_add),
    .din    (adc_d_q),
    .sum    (acc_sum),
    .wrap   (acc_wrap)
  );

  assign adc_d_d   = bus.adc_raw;
  assign diff      = $signed({1'b0, adc_d_q}) - $signed({1'b0, baseline_q});
  assign over_thr  = diff > $signed({1'b0, GATE_THR});
  assign block_avg = ADC_W'(acc_sum >> AVG_LOG2);
  assign pcnt_inc  = pcnt_q + 10'd1;
  assign timeout   = (pcnt_inc == MAXPULSE);

  always_comb begin
    state_d      = state_q;
    baseline_d   = baseline_q;
    bl_valid_d   = bl_valid_q;
    bl_relearn_d = 1'b0;
    pcnt_d       = pcnt_q;
    hold_d       = hold_q;
    acc_clear    = 1'b0;
    acc_add      = 1'b0;
    dyn_blcor_d  = (bl_valid_q && !diff[ADC_W]) ? diff[ADC_W-1:0] : '0;

    case (state_q)
      ST_INIT: begin
        acc_add = 1'b1;
        if (acc_wrap) begin
          baseline_d = block_avg;
          bl_valid_d = 1'b1;
          state_d    = ST_QUIET;
        end
      end
      ST_QUIET: begin
        // Gate test wins over a block completion; the partial block is dropped.
        if (over_thr) begin
          state_d   = ST_PULSE;
          acc_clear = 1'b1;
          pcnt_d    = 10'd1;
        end else begin
          acc_add = 1'b1;
          if (acc_wrap) baseline_d = block_avg;
        end
      end
      ST_PULSE: begin
        pcnt_d = pcnt_inc;
        if (!timeout && !over_thr) begin
          state_d = ST_HOLD;
          hold_d  = HOLDOFF - 8'd1;
        end
      end
      default: begin
        // Pulse counter keeps running through HOLD so pileup trains time out.
        pcnt_d = pcnt_inc;
        if (!timeout) begin
          if (over_thr) begin
            state_d = ST_PULSE;
          end else if (hold_q == 8'd0) begin
            state_d = ST_QUIET;
            pcnt_d  = 10'd0;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
    endcase

    if ((state_q == ST_PULSE || state_q == ST_HOLD) && timeout) begin
      state_d      = ST_INIT;
      bl_valid_d   = 1'b0;
      bl_relearn_d = 1'b1;
      pcnt_d       = 10'd0;
    end

    bl_gate_d = (state_d == ST_PULSE) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    adc_d_q <= adc_d_d;
    if (reset) begin
      state_q      <= ST_INIT;
      dyn_blcor_q  <= '0;
      baseline_q   <= '0;
      bl_valid_q   <= 1'b0;
      bl_gate_q    <= 1'b0;
      bl_relearn_q <= 1'b0;
      pcnt_q       <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      dyn_blcor_q  <= dyn_blcor_d;
      baseline_q   <= baseline_d;
      bl_valid_q   <= bl_valid_d;
      bl_gate_q    <= bl_gate_d;
      bl_relearn_q <= bl_relearn_d;
      pcnt_q       <= pcnt_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.dyn_blcor  = dyn_blcor_q;
  assign bus.baseline   = baseline_q;
  assign bus.bl_valid   = bl_valid_q;
  assign bus.bl_gate    = bl_gate_q;
  assign bus.bl_relearn = bl_relearn_q;

endmodule
`default_nettype wire

// File: tb/tb_dynode_baseline.sv
`default_nettype none
// ============================================================================
// tb_dynode_baseline : scoreboard bench for dynode_baseline against a
//                      sample-block behavioural model.  Rev 1.0
// ============================================================================
module tb_dynode_baseline;
  import dynode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  dynode_baseline_if bus ();

  dynode_baseline dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] blcor;
    logic [11:0] base;
    logic        valid;
    logic        gate;
    logic        relearn;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: last captured sample, baseline, and gate bookkeeping in plain counts.
  int m_adc_d     = 0;
  int m_base      = 0;
  bit m_valid     = 0;
  bit m_learning  = 1;
  bit m_gate      = 0;
  int m_age       = 0;
  int m_quiet_run = 0;
  int blk[$];

  task automatic step(input int raw, input bit rst);
    obs_t e;
    int   diff;
    bit   over;
    int   s;
    reset       = rst;
    bus.adc_raw = raw[11:0];
    e = '0;
    if (rst) begin
      m_base = 0; m_valid = 0; m_learning = 1; m_gate = 0;
      m_age = 0; m_quiet_run = 0; blk.delete();
    end else begin
      diff = m_adc_d - m_base;
      over = diff > int'(GATE_THR);
      e.blcor = (m_valid && diff > 0) ? 12'(diff) : 12'd0;
      e.relearn = 1'b0;
      if (m_learning || (!m_gate && !over)) begin
        blk.push_back(m_adc_d);
        if (blk.size() == (1 << AVG_LOG2)) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          m_base = s / (1 << AVG_LOG2);
          m_valid = 1; m_learning = 0;
          blk.delete();
        end
      end else if (!m_gate) begin
        m_gate = 1; m_age = 1; m_quiet_run = 0;
        blk.delete();
      end else begin
        m_age++;
        if (m_age == int'(MAXPULSE)) begin
          m_gate = 0; m_learning = 1; m_valid = 0; e.relearn = 1'b1;
        end else begin
          m_quiet_run = over ? 0 : m_quiet_run + 1;
          if (m_quiet_run == int'(HOLDOFF) + 1) m_gate = 0;
        end
      end
    end
    m_adc_d = raw;
    e.base  = 12'(m_base);
    e.valid = m_valid;
    e.gate  = m_gate;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  obs_t mon_e, mon_a;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a.blcor   = bus.dyn_blcor;
        mon_a.base    = bus.baseline;
        mon_a.valid   = bus.bl_valid;
        mon_a.gate    = bus.bl_gate;
        mon_a.relearn = bus.bl_relearn;
        n_tests++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got blcor=%0d base=%0d valid=%b gate=%b relearn=%b want blcor=%0d base=%0d valid=%b gate=%b relearn=%b",
                   $time, mon_a.blcor, mon_a.base, mon_a.valid, mon_a.gate, mon_a.relearn,
                   mon_e.blcor, mon_e.base, mon_e.valid, mon_e.gate, mon_e.relearn);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int r;
    // Reset and constant 200.
    repeat (3) step(200, 1'b1);
    check("reset_valid", int'(bus.bl_valid), 0);
    check("reset_base", int'(bus.baseline), 0);
    repeat (40) step(200, 1'b0);
    check("p1_base", int'(bus.baseline), 200);
    check("p1_valid", int'(bus.bl_valid), 1);
    check("p1_gate", int'(bus.bl_gate), 0);
    check("p1_blcor", int'(bus.dyn_blcor), 0);

    // Single excursion to 300.
    step(300, 1'b0);
    step(200, 1'b0);
    check("p2_blcor", int'(bus.dyn_blcor), 100);
    check("p2_gate", int'(bus.bl_gate), 1);
    repeat (30) step(200, 1'b0);
    check("p2_gate_closed", int'(bus.bl_gate), 0);
    check("p2_base", int'(bus.baseline), 200);

    // Downward step saturates and relearns.
    repeat (40) step(190, 1'b0);
    check("p3_base", int'(bus.baseline), 190);
    check("p3_blcor", int'(bus.dyn_blcor), 0);
    repeat (40) step(200, 1'b0);

    // Sustained 265 forces a timeout and relearn.
    repeat (630) step(265, 1'b0);
    check("p4_base", int'(bus.baseline), 265);
    check("p4_valid", int'(bus.bl_valid), 1);
    repeat (40) step(200, 1'b0);
    check("p4_back_base", int'(bus.baseline), 200);

    // Pileup train of 400 every 10 cycles.
    for (int i = 0; i < 600; i++) begin
      step((i % 10 == 0) ? 400 : 200, 1'b0);
      if (i == 300) begin
        check("p5_gate", int'(bus.bl_gate), 1);
        check("p5_base", int'(bus.baseline), 200);
      end
    end
    repeat (60) step(200, 1'b0);

    // Reset during a pulse, then relearn at 220.
    repeat (5) step(400, 1'b0);
    step(220, 1'b1);
    check("p6_gate", int'(bus.bl_gate), 0);
    check("p6_valid", int'(bus.bl_valid), 0);
    check("p6_base", int'(bus.baseline), 0);
    repeat (20) step(220, 1'b0);
    check("p6_relearn_base", int'(bus.baseline), 220);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 93)      v = 210 + int'($urandom_range(0, 20));
      else if (r < 98) v = 220 + int'($urandom_range(40, 1500));
      else             v = int'($urandom_range(0, 4095));
      step(v, ($urandom_range(0, 999) == 0));
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
